// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter using reverse double-dabble.
// One operand per request; outputs hold from one completed conversion to the next.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bin_out,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_SHIFT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    work;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    work_shifted;
    logic [W-1:0]    work_adj;
    logic [W-1:0]    acc_shifted;
    logic            any_bad;

    // One reverse double-dabble step: shift {work, acc} right, then correct
    // every BCD nibble that picked up a half-weight bit (value >= 8).
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        work_shifted = work >> 1;
        acc_shifted  = {work[0], acc[W-1:1]};
        work_adj     = work_shifted;
        any_bad      = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_shifted[4*d+3]) begin
                work_adj[4*d +: 4] = work_shifted[4*d +: 4] - 4'd3;
            end
            if (work[4*d +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            work    <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work  <= bcd_in;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (any_bad) begin
                        bin_out <= '0;
                        invalid <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_adj;
                    acc  <= acc_shifted;
                    cnt  <= cnt + CW'(1);
                    // The final shift completes the result in acc_shifted.
                    if (cnt == LAST_SHIFT) begin
                        bin_out <= acc_shifted;
                        invalid <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (DIGITS=4): directed cases plus
// randomized operands checked against an arithmetic decimal reference model.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [15:0] bin_out;
    logic        invalid;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_seq #(.DIGITS(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits, or invalid with a zero result.
    task automatic model(input logic [15:0] v, output logic [15:0] exp_bin, output logic exp_inv);
        int val;
        int dig;
        val     = 0;
        exp_inv = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            dig = int'((v >> (4 * i)) & 16'h000F);
            if (dig > 9) exp_inv = 1'b1;
            val = val * 10 + dig;
        end
        exp_bin = exp_inv ? 16'h0000 : 16'(val);
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat, output int busy_n, output bit held, input logic [15:0] prev);
        lat    = 1;
        busy_n = 0;
        held   = 1'b1;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            if (bin_out !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_n++;
    endtask

    task automatic run(input logic [15:0] v, input string tag);
        logic [15:0] exp_bin;
        logic        exp_inv;
        logic [15:0] prev;
        int          lat;
        int          busy_n;
        bit          held;
        model(v, exp_bin, exp_inv);
        @(negedge clk);
        prev   = bin_out;
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);
        wait_done(lat, busy_n, held, prev);
        check({tag, ".done"},    32'(done),    32'd1);
        check({tag, ".bin"},     32'(bin_out), 32'(exp_bin));
        check({tag, ".invalid"}, 32'(invalid), 32'(exp_inv));
        check({tag, ".latency"}, 32'(lat),     exp_inv ? 32'd2 : 32'd18);
        check({tag, ".busy_n"},  32'(busy_n),  exp_inv ? 32'd2 : 32'd18);
        check({tag, ".held"},    32'(held),    32'd1);
        @(negedge clk);
        check({tag, ".pulse"},   32'(done),    32'd0);
        check({tag, ".idle"},    32'(busy),    32'd0);
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] got_bin;
        int          n_done;
        int          lat;
        int          busy_n;
        bit          held;
        int          t_done [3];
        logic [15:0] b_done [3];

        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset.busy",    32'(busy),    32'd0);
        check("reset.done",    32'(done),    32'd0);
        check("reset.bin",     32'(bin_out), 32'd0);
        check("reset.invalid", 32'(invalid), 32'd0);
        reset = 1'b0;

        run(16'h1234, "r1234");
        run(16'h9999, "r9999");
        run(16'h0000, "r0000");
        run(16'h12A4, "r12A4");
        run(16'h0042, "r0042");

        // Second start during SHIFT with a changed operand must be ignored.
        @(negedge clk);
        bcd_in = 16'h0500;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        bcd_in = 16'h0777;
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n_done  = 0;
        got_bin = 16'hxxxx;
        for (int i = 0; i < 45; i++) begin
            if (done) begin
                n_done++;
                got_bin = bin_out;
            end
            @(negedge clk);
        end
        check("ignore.n_done", 32'(n_done),  32'd1);
        check("ignore.bin",    32'(got_bin), 32'h01F4);

        // Reset during SHIFT cycle 7 aborts; start in the release cycle is taken.
        bcd_in = 16'h4321;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 7; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort.busy",    32'(busy),    32'd0);
        check("abort.done",    32'(done),    32'd0);
        check("abort.bin",     32'(bin_out), 32'd0);
        check("abort.invalid", 32'(invalid), 32'd0);
        check("abort.no_done", 32'(n_done),  32'd0);
        reset  = 1'b0;
        start  = 1'b1;
        bcd_in = 16'h4321;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n, held, 16'h0000);
        check("restart.bin",     32'(bin_out), 32'h10E1);
        check("restart.latency", 32'(lat),     32'd18);
        @(negedge clk);

        // Start held high: three conversions, one idle cycle between them.
        bcd_in = 16'h0001;
        start  = 1'b1;
        n_done = 0;
        for (int t = 0; t < 80 && n_done < 3; t++) begin
            @(negedge clk);
            if (done) begin
                t_done[n_done] = t;
                b_done[n_done] = bin_out;
                n_done++;
            end
        end
        start = 1'b0;
        check("b2b.n_done", 32'(n_done), 32'd3);
        if (n_done == 3) begin
            check("b2b.gap1", 32'(t_done[1] - t_done[0]), 32'd19);
            check("b2b.gap2", 32'(t_done[2] - t_done[1]), 32'd19);
            for (int k = 0; k < 3; k++) check("b2b.bin", 32'(b_done[k]), 32'h0001);
        end
        repeat (3) @(negedge clk);

        // Randomized operands, roughly one in four carrying an illegal nibble.
        for (int n = 0; n < 16; n++) begin
            v = 16'h0000;
            for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            run(v, $sformatf("rand%0d_%04h", n, v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
